// File: rtl/serial_pkg.sv
// Shared types and constants for the serial data path (transmitter now, receiver later).
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    localparam int DEFAULT_CLKS_PER_BIT = 4;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts clocks within one serial bit and flags the last one.
module bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign tick = (count_q == LAST);

    // Wrapping on tick keeps the count at 0 at the start of every new bit.
    always_comb begin
        count_d = count_q + TW'(1);
        if (clear || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Framed parallel-to-serial transmitter: start, WIDTH data bits LSB first, stop.
// Defining SERIAL_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             q,
    output logic             busy,
    output tx_state_t        state_dbg
);

    // Handshake: a word transfers on a rising edge where valid && ready;
    // ready is a registered copy of (state == IDLE), and inputs are ignored otherwise.

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             q_q, q_d;
    logic             ready_q, ready_d;
`ifdef SERIAL_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif
    logic             tick;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock(clock),
        .reset(reset),
        .clear(state_q == IDLE),
        .tick (tick)
    );

    // q is computed for the next state so the line comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        q_d       = q_q;
        ready_d   = ready_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid && ready_q) begin
                    state_d   = START;
                    shift_d   = data_in;
                    bit_cnt_d = '0;
                    q_d       = LINE_START;
                    ready_d   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d  = 1'b0;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    q_d     = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BW'(1);
`ifdef SERIAL_TX_PARITY_EN
                    parity_d  = parity_q ^ shift_q[0];
`endif
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        q_d     = parity_q ^ shift_q[0];
`else
                        state_d = STOP;
                        q_d     = LINE_IDLE;
`endif
                    end else begin
                        q_d = shift_d[0];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    q_d     = LINE_IDLE;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    q_d     = LINE_IDLE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                q_d     = LINE_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            q_q       <= LINE_IDLE;
            ready_q   <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            q_q       <= q_d;
            ready_q   <= ready_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign q         = q_q;
    assign ready     = ready_q;
    assign busy      = ~ready_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: a frame-level line model checks two instances every cycle,
// while directed sequences pin literal frames, busy lengths and gaps.
module tb_serial_tx;
    import serial_pkg::*;

    localparam int W0 = 8;
    localparam int C0 = 4;
    localparam int W1 = 3;
    localparam int C1 = 1;
`ifdef SERIAL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FB0 = 2 + W0 + P;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [W0-1:0] data_in = '0;
    logic          valid = 1'b0;
    logic          ready0, q0, busy0;
    logic          ready1, q1, busy1;
    tx_state_t     st0, st1;

    int checks = 0;
    int passes = 0;
    logic [W0-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    serial_tx #(.WIDTH(W0), .CLKS_PER_BIT(C0)) dut0 (
        .clock(clock), .reset(reset), .data_in(data_in), .valid(valid),
        .ready(ready0), .q(q0), .busy(busy0), .state_dbg(st0)
    );

    serial_tx #(.WIDTH(W1), .CLKS_PER_BIT(C1)) dut1 (
        .clock(clock), .reset(reset), .data_in(data_in[W1-1:0]), .valid(valid),
        .ready(ready1), .q(q1), .busy(busy1), .state_dbg(st1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- frame-level line model ----------------
    bit   m_act[2] = '{0, 0};
    int   m_k[2]   = '{0, 0};
    int   m_nb[2]  = '{0, 0};
    logic m_fr[2][16];

    always @(posedge clock) begin
        int c;
        int w;
        logic [W0-1:0] d;
        logic eq, er, aq, ar, ab;
        for (int ch = 0; ch < 2; ch++) begin
            c = (ch == 0) ? C0 : C1;
            w = (ch == 0) ? W0 : W1;
            if (!reset) begin
                m_act[ch] = 0;
            end else if (m_act[ch]) begin
                m_k[ch]++;
                if (m_k[ch] == m_nb[ch] * c) m_act[ch] = 0;
            end else if (valid) begin
                d = (ch == 0) ? data_in : W0'(data_in[W1-1:0]);
                m_fr[ch][0] = 1'b0;
                for (int i = 0; i < w; i++) m_fr[ch][1 + i] = d[i];
                if (P == 1) m_fr[ch][w + 1] = ^d;
                m_fr[ch][w + 1 + P] = 1'b1;
                m_nb[ch]  = w + 2 + P;
                m_act[ch] = 1;
                m_k[ch]   = 0;
            end
        end
        #1;
        for (int ch = 0; ch < 2; ch++) begin
            c  = (ch == 0) ? C0 : C1;
            eq = m_act[ch] ? m_fr[ch][m_k[ch] / c] : 1'b1;
            er = !m_act[ch];
            aq = (ch == 0) ? q0 : q1;
            ar = (ch == 0) ? ready0 : ready1;
            ab = (ch == 0) ? busy0 : busy1;
            check($sformatf("model_q_ch%0d", ch), 32'(aq), 32'(eq));
            check($sformatf("model_ready_ch%0d", ch), 32'(ar), 32'(er));
            check($sformatf("model_busy_ch%0d", ch), 32'(ab), 32'(!er));
        end
    end

    // Length of the most recent busy run on instance 0.
    int busy_run = 0;
    int last_busy = 0;
    always @(posedge clock) begin
        #4;
        if (busy0) busy_run++;
        else if (busy_run != 0) begin
            last_busy = busy_run;
            busy_run  = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready0 !== 1'b1 && n < 200) begin
            tick_n(1);
            n++;
        end
        check("wait_ready", 32'(ready0), 32'd1);
    endtask

    task automatic start_word(input logic [W0-1:0] d, input bit keep);
        wait_ready();
        data_in = d;
        valid   = 1'b1;
        tick_n(1);
        check("handshake_ready_low", 32'(ready0), 32'd0);
        if (!keep) valid = 1'b0;
    endtask

    // Called in the first cycle of the start bit; samples each bit once.
    task automatic finish_word(output logic [15:0] seen);
        logic [W0-1:0] exp;
        seen = '0;
        for (int j = 0; j < FB0; j++) begin
            seen[j] = q0;
            if (j < FB0 - 1) tick_n(C0);
        end
        exp = exp_q.pop_front();
        check("frame_start_bit", 32'(seen[0]), 32'd0);
        check("frame_word", 32'(seen[W0:1]), 32'(exp));
        check("frame_stop_bit", 32'(seen[FB0-1]), 32'd1);
    endtask

    task automatic send_word(input logic [W0-1:0] d, input bit keep, output logic [15:0] seen);
        exp_q.push_back(d);
        start_word(d, keep);
        finish_word(seen);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [15:0] seen;
        int n;

        reset = 1'b0;
        repeat (3) begin
            tick_n(1);
            check("reset_q", 32'(q0), 32'd1);
            check("reset_ready", 32'(ready0), 32'd1);
            check("reset_busy", 32'(busy0), 32'd0);
        end
        reset = 1'b1;
        tick_n(2);

`ifdef SERIAL_TX_PARITY_EN
        send_word(8'h07, 0, seen);
        check("parity_frame_07", 32'(seen[10:0]), 32'b11000001110);
        wait_ready();
        tick_n(1);
        check("busy_len_parity", last_busy, 44);
`else
        send_word(8'hA5, 0, seen);
        check("frame_a5", 32'(seen[9:0]), 32'b1101001010);
        wait_ready();
        tick_n(1);
        check("busy_len", last_busy, 40);
`endif

        // Back-to-back with valid held high.
        send_word(8'h01, 1, seen);
        data_in = 8'hFF;
        wait_ready();
        n = 0;
        while (ready0 === 1'b1 && n < 10) begin
            n++;
            tick_n(1);
        end
        check("idle_gap", n, 1);
        valid = 1'b0;
        exp_q.push_back(8'hFF);
        finish_word(seen);
        check("b2b_all_ones", 32'(seen[W0:1]), 32'hFF);

        // Reset during data bit 3.
        start_word(8'h55, 0);
        tick_n(4 * C0 + 1);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_q", 32'(q0), 32'd1);
        check("async_reset_ready", 32'(ready0), 32'd1);
        check("async_reset_busy", 32'(busy0), 32'd0);
        tick_n(2);
        reset = 1'b1;
        tick_n(1);
        send_word(8'h00, 0, seen);
`ifdef SERIAL_TX_PARITY_EN
        check("after_reset_frame", 32'(seen[10:0]), 32'b10000000000);
`else
        check("after_reset_frame", 32'(seen[9:0]), 32'b1000000000);
`endif

        // Input changes while busy are ignored.
        exp_q.push_back(8'h3C);
        start_word(8'h3C, 0);
        fork
            finish_word(seen);
            begin
                tick_n(6);
                data_in = 8'hFF;
                valid   = 1'b1;
                tick_n(2);
                valid   = 1'b0;
            end
        join
        check("ignored_frame", 32'(seen[W0:1]), 32'h3C);
        wait_ready();
        n = 0;
        repeat (30) begin
            tick_n(1);
            if (busy0) n++;
        end
        check("no_extra_frame", n, 0);

        // Random traffic, checked by the line model.
        repeat (2500) begin
            tick_n(1);
            valid   = ($urandom_range(0, 3) == 0);
            data_in = W0'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0;
                tick_n(1);
                reset = 1'b1;
            end
        end
        valid = 1'b0;
        wait_ready();
        tick_n(2);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-to-serial transmitter that drives a single-bit line for a downstream `flipflop` capture stage or a serial receiver. It accepts a WIDTH-bit word over a valid/ready handshake and emits a framed word on `q`: start bit, data LSB first, optional parity, then stop bit. Each bit is held for CLKS_PER_BIT clocks. It sits at the driving end of the team's serial data path and provides the stimulus side that the capture flops sample.

## Interface
- `WIDTH`, default 8: data word width, 1 or greater.
- `CLKS_PER_BIT`, default 4: clocks per serial bit, 1 or greater.

- `clock`, in, 1: single clock domain; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `data_in`, in, WIDTH: word to send; sampled only on a handshake.
- `valid`, in, 1: a word is offered.
- `ready`, out, 1: transmitter can accept a word.
- `q`, out, 1: serial line; idle level is 1.
- `busy`, out, 1: a frame is in progress (`~ready`).

## Operation
- States, defined as `tx_state_t`: IDLE, START, DATA, PARITY, STOP.
- Reset values: state IDLE, `q`=1, `ready`=1, `busy`=0, bit counter 0, timer 0, shift register 0.
- IDLE:
  - `q`=1 and `ready`=1.
  - When `valid && ready` is true at a rising edge, latch `data_in` into the shift register and go to START.
- START: `q`=0 for CLKS_PER_BIT clocks, then go to DATA.
- DATA:
  - `q` = shift register bit 0. Shift right at the end of each bit period.
  - After WIDTH bits, go to PARITY when `SERIAL_TX_PARITY_EN` is defined, otherwise go to STOP.
- PARITY: `q` = XOR of the latched word (even parity), for CLKS_PER_BIT clocks, then go to STOP.
- STOP: `q`=1 for CLKS_PER_BIT clocks, then go to IDLE.
- `ready` = (state == IDLE), registered. It is low from the clock after the handshake until the STOP period ends.
- Changes to `data_in` or `valid` while `ready`=0 are ignored. The frame content is fixed at the handshake.
- Bit counter width is $clog2(WIDTH+1). Timer width is $clog2(CLKS_PER_BIT+1). The timer resets to 0 at each state change.
- CLKS_PER_BIT=1: each bit lasts exactly one clock; there is no divider-related special case.
- Reset asserted mid-frame: `q` goes to 1 and `ready` to 1 immediately (asynchronous). The frame is abandoned. No partial resume after reset deasserts.

## Timing
- Let t0 be the handshake edge.
- `q` changes to the start bit on edge t0. It holds for clocks [t0, t0+C), where C = CLKS_PER_BIT.
- Data bit i occupies [t0+(1+i)·C, t0+(2+i)·C).
- Frame length is (2 + WIDTH + P)·C clocks, where P=1 when parity is compiled in, otherwise 0.
- `ready` returns to 1 on the edge that ends STOP.
- Back-to-back words with `valid` held high: exactly one idle clock (`q`=1, `ready`=1) separates the stop bit from the next start bit.
- `q` is driven directly from a flop. There is no combinational path from any input to `q`.

## Configuration
- `SERIAL_TX_PARITY_EN` defined:
  - PARITY state and parity logic are present.
  - Frame is WIDTH+3 bits.
- Not defined:
  - PARITY state is unreachable and its logic is omitted.
  - Frame is WIDTH+2 bits.
- Parity is always even. There is no odd-parity option.

## Structure
- Package `serial_pkg` contains:
  - `tx_state_t` enum.
  - `LINE_IDLE`=1'b1 and `LINE_START`=1'b0.
  - Default CLKS_PER_BIT constant, shared with the future receiver.
- Sub-module `bit_timer`:
  - Parameterised by CLKS_PER_BIT.
  - Inputs: `clock`, `reset`, `clear`.
  - Output: `tick`, high on the last clock of a bit period.
- The top level contains the FSM, shift register, bit counter and parity accumulator.

## Test plan
- Reset: hold `reset`=0 for 3 clocks. Required: `q`=1, `ready`=1, `busy`=0 throughout, and immediately when `reset` asserts.
- Single word, WIDTH=8, C=4, no parity, send 8'hA5. Required:
  - `q` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks.
  - `ready` low for exactly 40 clocks.
- Parity build, send 8'h07. Required: 11-bit frame with parity bit 1 and stop bit 1; 44 clocks busy.
- Back-to-back: `valid` held high with 8'h01 then 8'hFF. Required:
  - Exactly one `q`=1 idle clock between the first stop bit and the second start bit.
  - Second frame bits are all 1.
- Reset mid-frame: send 8'h55 and pull `reset` low during data bit 3. Required:
  - `q`=1 and `ready`=1 asynchronously.
  - The next word, 8'h00, is sent as a complete correct frame.
- Ignored input: change `data_in` to 8'hFF and pulse `valid` while `ready`=0 during an 8'h3C frame. Required: the frame carries 8'h3C, and no extra frame follows.
